// File: rtl/jt51_pm_src.sv
// jt51_pm_src -- phase-modulation source for the key-code PM adder.
//
// Builds the PM offset as an unsigned magnitude (mod) plus a direction
// flag (add). An LFO rate accumulator advances an 8-bit phase counter.
// The phase is shaped into a signed waveform, scaled by PMD and shifted
// by PMS. The result is registered so that downstream logic only ever
// sees clean, registered values.
//
// Optional build macro:
//   JT51_PMSRC_NOISE_EN - include the 17-bit noise LFSR so that lfo_w = 3
//                         selects noise. Without it, lfo_w = 3 behaves as
//                         triangle and NOISE_SEED is unused.
//
// Ports:
//   clk       in   1  system clock
//   rst       in   1  synchronous active-high reset
//   cen       in   1  clock enable, all state advances only when high
//   lfo_freq  in   8  [7:4] exponent, [3:0] mantissa of the LFO rate
//   lfo_w     in   2  waveform: 0 saw, 1 square, 2 triangle, 3 noise
//   pmd       in   7  PM depth
//   pms       in   3  PM sensitivity, 0 disables PM
//   lfo_rst   in   1  test-register LFO reset (level)
//   mod       out  9  PM magnitude
//   add       out  1  1 = add mod to key code, 0 = subtract
//   tick      out  1  pulse when the LFO phase advanced this cycle
//   phase     out  8  current LFO phase

module jt51_pm_src #(
    parameter logic [16:0] NOISE_SEED = 17'h1_5A5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] lfo_freq,
    input  logic [1:0] lfo_w,
    input  logic [6:0] pmd,
    input  logic [2:0] pms,
    input  logic       lfo_rst,
    output logic [8:0] mod,
    output logic       add,
    output logic       tick,
    output logic [7:0] phase
);

    logic [19:0] acc;
    logic [19:0] inc;
    logic [20:0] acc_sum;
    logic        carry;

    // The mantissa carries an implicit leading one, so even lfo_freq = 0
    // still advances the accumulator.
    assign inc     = 20'({1'b1, lfo_freq[3:0]}) << lfo_freq[7:4];
    assign acc_sum = {1'b0, acc} + {1'b0, inc};
    assign carry   = acc_sum[20];

    // lfo_rst clears the LFO even while cen is low and beats a coincident carry
    always_ff @(posedge clk) begin
        if (rst || lfo_rst) begin
            acc   <= '0;
            phase <= '0;
            tick  <= 1'b0;
        end else if (cen) begin
            acc  <= acc_sum[19:0];
            tick <= carry;
            if (carry)
                phase <= phase + 8'd1;
        end else begin
            tick <= 1'b0;
        end
    end

`ifdef JT51_PMSRC_NOISE_EN
    logic [16:0] lfsr;

    // The noise LFSR steps together with the phase and is not cleared by lfo_rst
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= NOISE_SEED;
        else if (cen && carry && !lfo_rst)
            lfsr <= {lfsr[15:0], lfsr[16] ^ lfsr[13]};
    end
`else
    logic unused_seed;
    assign unused_seed = ^NOISE_SEED;
`endif

    logic [8:0] w;
    logic [5:0] tri_t;
    logic [7:0] tri_mag;
    logic [7:0] w_mag;
    logic [6:0] a;
    logic [8:0] m;

    // The waveform is held as a 9-bit two's-complement value. Then it is
    // reduced to a magnitude, scaled by depth and shifted by sensitivity.
    always_comb begin
        tri_t   = phase[6] ? ~phase[5:0] : phase[5:0];
        tri_mag = {1'b0, tri_t, 1'b0};
        w       = '0;
        case (lfo_w)
            2'd0:    w = {1'b0, phase} - 9'd128;
            2'd1:    w = phase[7] ? 9'h180 : 9'h07F;
`ifdef JT51_PMSRC_NOISE_EN
            2'd3:    w = {lfsr[7], lfsr[7:0]};
`endif
            default: w = phase[7] ? (9'd0 - {1'b0, tri_mag}) : {1'b0, tri_mag};
        endcase
        // -128 maps to 8'h80, which still reads as 128 unsigned
        w_mag = w[8] ? 8'(~w[7:0] + 8'd1) : w[7:0];
        a     = 7'((15'(w_mag) * 15'(pmd)) >> 7);
        if (pms == 3'd0)
            m = '0;
        else
            m = 9'({a, 2'b00}) >> (3'd7 - pms);
    end

    // A zero offset always reports add = 1 so the key-code path never sees -0
    always_ff @(posedge clk) begin
        if (rst) begin
            mod <= '0;
            add <= 1'b1;
        end else if (cen) begin
            mod <= m;
            add <= ~w[8] | (m == 9'd0);
        end
    end

endmodule

// File: tb/tb_jt51_pm_src.sv
// tb_jt51_pm_src -- self-checking bench for jt51_pm_src.
// Uses fixed vectors for the waveform and scaling cases, hand-written
// sequences for the rate, lfo_rst, clock-enable and noise behaviour, and
// randomized traffic compared against an arithmetic reference model.

module tb_jt51_pm_src;

    localparam logic [16:0] SEED = 17'h1_5A5A;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic [7:0] lfo_freq;
    logic [1:0] lfo_w;
    logic [6:0] pmd;
    logic [2:0] pms;
    logic       lfo_rst;
    logic [8:0] mod;
    logic       add;
    logic       tick;
    logic [7:0] phase;

    jt51_pm_src #(.NOISE_SEED(SEED)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .lfo_freq (lfo_freq),
        .lfo_w    (lfo_w),
        .pmd      (pmd),
        .pms      (pms),
        .lfo_rst  (lfo_rst),
        .mod      (mod),
        .add      (add),
        .tick     (tick),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_acc;
    int m_phase;
    int m_lfsr;
    int m_mod;
    int m_add;
    int m_tick;

    typedef struct {
        logic [7:0] ph;
        logic [1:0] wsel;
        logic [6:0] depth;
        logic [2:0] sens;
        int         exp_mod;
        int         exp_add;
    } vec_t;

    vec_t vecs[$];

    // Signed waveform value from the phase and the noise byte
    function automatic int wave_value(input int ph, input int lf, input int wsel);
        int t;
        int mag;
        if (wsel == 3) begin
`ifdef JT51_PMSRC_NOISE_EN
            return (lf >= 128) ? lf - 256 : lf;
`else
            wsel = 2;
`endif
        end
        if (wsel == 0) return ph - 128;
        if (wsel == 1) return (ph >= 128) ? -128 : 127;
        t   = ((ph % 128) >= 64) ? 63 - (ph % 64) : (ph % 64);
        mag = 2 * t;
        return (ph >= 128) ? -mag : mag;
    endfunction

    function automatic int scaled_mod(input int w, input int depth, input int sens);
        int a;
        a = (((w < 0) ? -w : w) * depth) / 128;
        if (sens == 0) return 0;
        return (a * 4) / (1 << (7 - sens));
    endfunction

    task automatic model_edge();
        int w;
        int m;
        int sum;
        if (rst) begin
            m_acc = 0; m_phase = 0; m_lfsr = int'(SEED);
            m_mod = 0; m_add = 1; m_tick = 0;
            return;
        end
        if (cen) begin
            w     = wave_value(m_phase, m_lfsr % 256, int'(lfo_w));
            m     = scaled_mod(w, int'(pmd), int'(pms));
            m_mod = m;
            m_add = (w >= 0 || m == 0) ? 1 : 0;
        end
        if (lfo_rst) begin
            m_acc = 0; m_phase = 0; m_tick = 0;
        end else if (cen) begin
            sum    = m_acc + ((16 + int'(lfo_freq[3:0])) << int'(lfo_freq[7:4]));
            m_tick = (sum >= (1 << 20)) ? 1 : 0;
            m_acc  = sum % (1 << 20);
            if (m_tick == 1) begin
                m_phase = (m_phase + 1) % 256;
                m_lfsr  = ((m_lfsr * 2) % (1 << 17)) + (((m_lfsr >> 16) ^ (m_lfsr >> 13)) & 1);
            end
        end else begin
            m_tick = 0;
        end
    endtask

    task automatic check_value(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        check_value({tag, "_mod"},   int'(mod),   m_mod);
        check_value({tag, "_add"},   int'(add),   m_add);
        check_value({tag, "_tick"},  int'(tick),  m_tick);
        check_value({tag, "_phase"}, int'(phase), m_phase);
    endtask

    // One clock edge: the model follows the edge and outputs are sampled 1 time unit later
    task automatic step_cycle(input bit do_check, input string tag);
        @(posedge clk);
        model_edge();
        #1;
        if (do_check) checkOutput(tag);
    endtask

    // Clear the LFO and run at two cycles per tick until phase == target.
    // The accumulator is back at zero and the LFO is parked at the slowest rate.
    task automatic reach_phase(input int target);
        lfo_rst  = 1'b1;
        step_cycle(1'b0, "reach");
        lfo_rst  = 1'b0;
        lfo_freq = 8'hF0;
        repeat (2 * target) step_cycle(1'b0, "reach");
        lfo_freq = 8'h00;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        reach_phase(int'(v.ph));
        lfo_w = v.wsel;
        pmd   = v.depth;
        pms   = v.sens;
        step_cycle(1'b0, "vec");
        check_value($sformatf("vec%0d_mod", idx),   int'(mod),   v.exp_mod);
        check_value($sformatf("vec%0d_add", idx),   int'(add),   v.exp_add);
        check_value($sformatf("vec%0d_phase", idx), int'(phase), int'(v.ph));
    endtask

    initial begin
        int  cnt;
        bit  got;
        int  rec_mod[200];
        int  rec_add[200];

        vecs.push_back('{8'h00, 2'd0, 7'd127, 3'd7, 508, 0});
        vecs.push_back('{8'hFF, 2'd0, 7'd127, 3'd7, 504, 1});
        vecs.push_back('{8'h80, 2'd0, 7'd127, 3'd7,   0, 1});
        vecs.push_back('{8'h20, 2'd2, 7'd64,  3'd4,  16, 1});
        vecs.push_back('{8'hA0, 2'd2, 7'd64,  3'd4,  16, 0});
        vecs.push_back('{8'h20, 2'd2, 7'd64,  3'd0,   0, 1});
        vecs.push_back('{8'hA0, 2'd2, 7'd64,  3'd0,   0, 1});
        vecs.push_back('{8'h10, 2'd1, 7'd127, 3'd7, 504, 1});
        vecs.push_back('{8'h90, 2'd1, 7'd127, 3'd7, 508, 0});
        vecs.push_back('{8'h7F, 2'd2, 7'd127, 3'd7,   0, 1});
        vecs.push_back('{8'h40, 2'd2, 7'd127, 3'd7, 500, 1});
        vecs.push_back('{8'h40, 2'd0, 7'd100, 3'd3,  12, 0});
        vecs.push_back('{8'hC0, 2'd0, 7'd127, 3'd1,   3, 1});
`ifndef JT51_PMSRC_NOISE_EN
        vecs.push_back('{8'hA0, 2'd3, 7'd64,  3'd4,  16, 0});
`endif

        // Reset with cen high and arbitrary inputs
        rst = 1'b1; cen = 1'b1; lfo_freq = 8'h5A; lfo_w = 2'd1;
        pmd = 7'd99; pms = 3'd5; lfo_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step_cycle(1'b0, "reset");
            check_value("reset_mod",   int'(mod),   0);
            check_value("reset_add",   int'(add),   1);
            check_value("reset_phase", int'(phase), 0);
            check_value("reset_tick",  int'(tick),  0);
        end
        rst = 1'b0;

        // Fastest plain rate: a tick on every second cycle
        lfo_rst = 1'b1; lfo_freq = 8'hF0;
        step_cycle(1'b1, "rate_clr");
        lfo_rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step_cycle(1'b0, "rate");
            check_value($sformatf("rate_tick%0d", i), int'(tick), i % 2);
        end
        check_value("rate_phase_80", int'(phase), 128);

        // Slowest rate: the first tick comes after exactly 65536 cycles
        lfo_rst = 1'b1; lfo_freq = 8'h00;
        step_cycle(1'b1, "slow_clr");
        lfo_rst = 1'b0;
        cnt = 0; got = 1'b0;
        while (cnt < 70000 && !got) begin
            step_cycle(1'b0, "slow");
            cnt++;
            if (tick === 1'b1) got = 1'b1;
        end
        check_value("slow_first_tick_cycles", cnt, 65536);
        check_value("slow_phase", int'(phase), 1);

        // Waveform, depth and sensitivity vectors
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // lfo_rst while a carry is due: clears phase and restarts the accumulator
        reach_phase(8'h37);
        lfo_freq = 8'hF0;
        step_cycle(1'b1, "lrst_pre");
        check_value("lrst_pre_phase", int'(phase), 8'h37);
        lfo_rst = 1'b1;
        step_cycle(1'b1, "lrst");
        check_value("lrst_phase", int'(phase), 0);
        check_value("lrst_tick",  int'(tick),  0);
        lfo_rst = 1'b0;
        step_cycle(1'b1, "lrst_post1");
        check_value("lrst_post1_tick", int'(tick), 0);
        step_cycle(1'b1, "lrst_post2");
        check_value("lrst_post2_tick",  int'(tick),  1);
        check_value("lrst_post2_phase", int'(phase), 1);

        // cen low freezes phase and mod
        reach_phase(8'h10);
        lfo_w = 2'd0; pmd = 7'd127; pms = 3'd7;
        step_cycle(1'b1, "frz_load");
        check_value("frz_load_mod", int'(mod), 444);
        cen = 1'b0; lfo_freq = 8'hF0; pmd = 7'd3;
        for (int i = 0; i < 10; i++) begin
            step_cycle(1'b1, "frz");
            check_value($sformatf("frz%0d_phase", i), int'(phase), 8'h10);
            check_value($sformatf("frz%0d_mod", i),   int'(mod),   444);
            check_value($sformatf("frz%0d_tick", i),  int'(tick),  0);
        end
        cen = 1'b1;

`ifdef JT51_PMSRC_NOISE_EN
        // Noise from the known seed: 0x5A before the first tick, 0xB5 after it
        rst = 1'b1;
        step_cycle(1'b1, "nz_rst");
        rst = 1'b0; lfo_freq = 8'hF0; lfo_w = 2'd3; pmd = 7'd127; pms = 3'd7;
        step_cycle(1'b1, "nz1");
        check_value("nz1_mod", int'(mod), 356);
        check_value("nz1_add", int'(add), 1);
        step_cycle(1'b1, "nz2");
        step_cycle(1'b1, "nz3");
        check_value("nz3_mod", int'(mod), 296);
        check_value("nz3_add", int'(add), 0);
        for (int i = 0; i < 300; i++) step_cycle(1'b1, "nz_run");
`else
        // lfo_w = 3 must track a triangle run cycle for cycle
        lfo_rst = 1'b1; lfo_freq = 8'hF4; lfo_w = 2'd2; pmd = 7'd90; pms = 3'd6;
        step_cycle(1'b1, "tri_clr");
        lfo_rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step_cycle(1'b1, "tri_run");
            rec_mod[i] = m_mod;
            rec_add[i] = m_add;
        end
        lfo_rst = 1'b1; lfo_w = 2'd3;
        step_cycle(1'b1, "w3_clr");
        lfo_rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step_cycle(1'b0, "w3_run");
            check_value($sformatf("w3_mod%0d", i), int'(mod), rec_mod[i]);
            check_value($sformatf("w3_add%0d", i), int'(add), rec_add[i]);
        end
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cen      = ($urandom_range(0, 7) != 0);
            lfo_rst  = ($urandom_range(0, 63) == 0);
            lfo_freq = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : {4'($urandom_range(12, 15)), 4'($urandom_range(0, 15))};
            if (i % 40 == 0) begin
                lfo_w = 2'($urandom_range(0, 3));
                pmd   = 7'($urandom_range(0, 127));
                pms   = 3'($urandom_range(0, 7));
            end
            step_cycle(1'b1, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
